// File: rtl/operand_frame_loader.sv
// rtl/operand_frame_loader.sv - serial-to-parallel operand frame loader with registered compare result
// Assembles x1,y1,x2,y2 from a valid/ready bit stream and captures the compare stage result on consume.
module operand_frame_loader #(
  parameter int FRAME_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic din_sof,
  input  logic din_valid,
  output logic din_ready,
  output logic x1,
  output logic y1,
  output logic x2,
  output logic y2,
  output logic op_valid,
  input  logic op_ready,
  input  logic b_in,
  output logic b_q,
  output logic b_valid,
  output logic frame_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] ops_q, ops_d;
  logic                  res_q, res_d;
  logic                  res_valid_q, res_valid_d;
  logic                  err_q, err_d;
  logic                  accept;

  // Handshake outputs decode state only, so no input reaches them combinationally.
  assign din_ready = (state_q != ST_FULL);
  assign op_valid  = (state_q == ST_FULL);
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ops_d       = ops_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (din_sof) begin
            ops_d[0] = din;
            cnt_d    = 2'd1;
            state_d  = ST_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          // An sof mid-frame restarts the frame; stale upper bits are overwritten later.
          if (din_sof) begin
            ops_d[0] = din;
            cnt_d    = 2'd1;
            err_d    = 1'b1;
          end else begin
            ops_d[cnt_q] = din;
            if (cnt_q == 2'd3) begin
              cnt_d   = 2'd0;
              state_d = ST_FULL;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
      end
      ST_FULL: begin
        if (op_ready) begin
          res_d       = b_in;
          res_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      ops_q       <= '0;
      res_q       <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ops_q       <= ops_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign x1        = ops_q[0];
  assign y1        = ops_q[1];
  assign x2        = ops_q[2];
  assign y2        = ops_q[3];
  assign b_q       = res_q;
  assign b_valid   = res_valid_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_operand_frame_loader.sv
// tb/tb_operand_frame_loader.sv - self-checking bench for operand_frame_loader
// Frame-level model of collected bits plus directed literal checks.
module tb_operand_frame_loader;

  logic clk = 1'b0;
  logic reset, din, din_sof, din_valid, din_ready;
  logic x1, y1, x2, y2, op_valid, op_ready, b_in, b_q, b_valid, frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bv_count = 0;
  bit chk_en = 1'b0;
  bit in_b2b = 1'b0;
  int b2b_cyc[$];

  always #5 clk = ~clk;

  operand_frame_loader #(.FRAME_BITS(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_sof(din_sof), .din_valid(din_valid),
    .din_ready(din_ready), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .op_valid(op_valid),
    .op_ready(op_ready), .b_in(b_in), .b_q(b_q), .b_valid(b_valid), .frame_err(frame_err)
  );

  // Comparison stage: f = {y2,x2,y1,x1}; b = {x2,x1} > {y2,y1}.
  function automatic logic cmp(input logic [3:0] f);
    return ({f[2], f[0]} > {f[3], f[1]});
  endfunction

  assign b_in = cmp({y2, x2, y1, x1});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: list of collected bits per frame, completed frame waiting for consumption.
  logic [3:0] m_ops;
  bit m_pend, m_bq, m_bv, m_err;
  int nbits;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ops = 4'd0; m_pend = 0; nbits = 0; m_bq = 0; m_bv = 0; m_err = 0;
      chk_en = 1'b1;
    end else begin
      m_bv = 0;
      m_err = 0;
      if (m_pend) begin
        if (op_ready) begin
          m_bq = cmp(m_ops);
          m_bv = 1;
          m_pend = 0;
        end
      end else if (din_valid) begin
        if (din_sof) begin
          if (nbits != 0) m_err = 1;
          m_ops[0] = din;
          nbits = 1;
        end else if (nbits == 0) begin
          m_err = 1;
        end else begin
          m_ops[nbits] = din;
          nbits++;
        end
        if (nbits == 4) begin
          m_pend = 1;
          nbits = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("din_ready", din_ready, !m_pend);
      chk("op_valid", op_valid, m_pend);
      chk("operands", {y2, x2, y1, x1}, m_ops);
      chk("b_q", b_q, m_bq);
      chk("b_valid", b_valid, m_bv);
      chk("frame_err", frame_err, m_err);
      if (b_valid) begin
        bv_count++;
        if (in_b2b) b2b_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_bit(input logic s, input logic d);
    int t = 0;
    while (!din_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL din_ready_timeout actual=0 required=1");
    end
    din_valid = 1'b1; din_sof = s; din = d;
    @(negedge clk);
    din_valid = 1'b0; din_sof = 1'b0; din = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] f);
    send_bit(1'b1, f[0]);
    for (int i = 1; i < 4; i++) send_bit(1'b0, f[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv0;
    reset = 1'b1; din = 1'b0; din_sof = 1'b0; din_valid = 1'b0; op_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", din_ready, 1);
    chk("rst_ops", {y2, x2, y1, x1}, 4'b0000);
    reset = 1'b0;

    // Frame 1,0,1,1 -> b = (3 > 2) = 1
    send_frame(4'b1101);
    chk("t1_op_valid", op_valid, 1);
    chk("t1_ops", {y2, x2, y1, x1}, 4'b1101);
    @(negedge clk);
    chk("t1_b_valid", b_valid, 1);
    chk("t1_b_q", b_q, 1);
    chk("t1_ready", din_ready, 1);

    // Reset mid-frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rm_ops", {y2, x2, y1, x1}, 4'b0000);
    chk("rm_b_q", b_q, 0);
    chk("rm_ready", din_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("rm_no_op_valid", op_valid, 0);
      chk("rm_no_b_valid", b_valid, 0);
    end

    // Missing sof, then frame 0,1,0,1 -> b = (0 > 3) = 0
    send_bit(1'b0, 1'b1);
    chk("ms_err", frame_err, 1);
    chk("ms_ready", din_ready, 1);
    @(negedge clk);
    chk("ms_err_clear", frame_err, 0);
    send_frame(4'b1010);
    chk("ms_ops", {y2, x2, y1, x1}, 4'b1010);
    @(negedge clk);
    chk("ms_b_valid", b_valid, 1);
    chk("ms_b_q", b_q, 0);

    // Early restart: delivered 0,0,1,1 -> b = (2 > 2) = 0
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    chk("er_err", frame_err, 1);
    send_bit(1'b0, 1'b0);
    chk("er_err_clear", frame_err, 0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("er_op_valid", op_valid, 1);
    chk("er_ops", {y2, x2, y1, x1}, 4'b1100);
    @(negedge clk);
    chk("er_b_valid", b_valid, 1);

    // Backpressure: frame 0,0,1,0 -> b = (2 > 0) = 1, extra bits offered while full
    op_ready = 1'b0;
    send_frame(4'b0100);
    din_valid = 1'b1; din_sof = 1'b1; din = 1'b1;
    repeat (5) begin
      chk("bp_ready_low", din_ready, 0);
      chk("bp_op_valid", op_valid, 1);
      chk("bp_ops", {y2, x2, y1, x1}, 4'b0100);
      @(negedge clk);
    end
    din_valid = 1'b0; din_sof = 1'b0; din = 1'b0;
    op_ready = 1'b1;
    bv0 = bv_count;
    @(negedge clk);
    chk("bp_b_valid", b_valid, 1);
    chk("bp_b_q", b_q, 1);
    chk("bp_ready", din_ready, 1);
    @(negedge clk);
    chk("bp_b_valid_once", bv_count - bv0, 1);

    // Back-to-back: all 16 patterns
    in_b2b = 1'b1;
    bv0 = bv_count;
    for (int p = 0; p < 16; p++) send_frame(p[3:0]);
    repeat (3) @(negedge clk);
    in_b2b = 1'b0;
    chk("b2b_count", bv_count - bv0, 16);
    for (int i = 1; i < b2b_cyc.size(); i++)
      chk("b2b_spacing", b2b_cyc[i] - b2b_cyc[i-1], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_frame_loader.md
# operand_frame_loader

Upstream feeder for the 2-bit operand comparison stage. It assembles one 4-bit operand frame (x1, y1, x2, y2) from a serial bit stream with valid/ready handshaking, and presents the four operand bits stable to the combinational stage. It then captures that stage's single-bit result `b` back into a registered result output. It is the sequential front end that lets the combinational block be driven from a narrow serial source.

## Interface
- `FRAME_BITS`, 4: bits per frame. Fixed at 4; other values are unsupported.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `din`  input  1  serial operand bit.
- `din_sof`  input  1  start-of-frame marker; qualifies `din` as frame bit 0.
- `din_valid`  input  1  `din`/`din_sof` valid this cycle.
- `din_ready`  output  1  loader can accept a bit this cycle.
- `x1`, `y1`, `x2`, `y2`  output  1 each  assembled operand bits; drive the comparison stage.
- `op_valid`  output  1  operand bits are complete and stable.
- `op_ready`  input  1  downstream consumes the operands this cycle.
- `b_in`  input  1  result from the comparison stage (combinational from x1..y2).
- `b_q`  output  1  registered result of the last consumed frame.
- `b_valid`  output  1  one-cycle pulse: `b_q` just updated.
- `frame_err`  output  1  one-cycle pulse: framing violation detected.

## Operation
- Accept = `din_valid & din_ready` at a rising edge.
- Bit order within a frame: bit0→`x1`, bit1→`y1`, bit2→`x2`, bit3→`y2`.
- State machine: IDLE, SHIFT, FULL. 2-bit bit counter `cnt`.
  - IDLE: `din_ready`=1.
    - Accept with `din_sof`=1: store bit0, `cnt`←1, go to SHIFT.
    - Accept with `din_sof`=0: bit discarded, `frame_err` pulses, stay in IDLE.
  - SHIFT: `din_ready`=1.
    - Accept with `din_sof`=0: store bit at index `cnt`, `cnt`←`cnt`+1.
    - When the stored index is 3: `cnt`←0, go to FULL.
    - Accept with `din_sof`=1 (early restart): partial frame dropped, this bit becomes bit0, `cnt`←1, `frame_err` pulses, stay in SHIFT.
  - FULL: `din_ready`=0, `op_valid`=1; `x1..y2` held constant.
    - `op_valid & op_ready`: `b_q`←`b_in`, `b_valid` pulses next cycle, go to IDLE.
- Operand registers retain their last values in IDLE and SHIFT, but bits are written in place as they arrive. Downstream treats `x1..y2` as meaningful only while `op_valid`=1.
- `din_valid` without `din_ready` (FULL): input ignored, no error.
- Reset mid-frame or in FULL: partial or complete frame discarded, and no `b_valid` is generated for it.

## Timing
- All outputs are registered except `din_ready` and `op_valid`, which are decoded from state only. Neither has a combinational path from any input.
- Reset values (after the first edge with `reset`=1): state IDLE, `cnt`=0, `x1`=`y1`=`x2`=`y2`=0, `op_valid`=0, `din_ready`=1, `b_q`=0, `b_valid`=0, `frame_err`=0.
- Latency: the bit3 accept edge sets `op_valid`=1 in the following cycle. Minimum frame-to-`op_valid` is 4 accept cycles.
- `op_ready` held high: FULL lasts exactly 1 cycle. The consume edge returns the loader to IDLE, `din_ready`=1 the next cycle. `b_valid` is high that same cycle.
- Peak throughput is 1 frame per 5 cycles.
- `b_in` is sampled on the consume edge only. The comparison stage settles within the cycle because the operands are stable for the whole FULL period.
- `frame_err` and `b_valid` are single-cycle pulses, asserted the cycle after the causing edge. They never stretch.
- `reset` overrides every other input in the same edge.

## Test plan
- Reset then frame: bits 1,0,1,1 with sof on the first, `op_ready`=1 → `op_valid` high for 1 cycle with x1=1, y1=0, x2=1, y2=1; `b_q` equals the comparison result for that frame; `b_valid` pulses once.
- Backpressure: complete frame, `op_ready`=0 for 5 cycles → `din_ready`=0 and operands unchanged for 5 cycles; extra `din_valid` bits ignored; release → single `b_valid`.
- Missing sof: `din_valid` with `din_sof`=0 in IDLE → `frame_err` 1-cycle pulse, no state change. A following sof frame 0,1,0,1 loads correctly.
- Early restart: sof,1 / 1 / sof,0 / 0 / 1 / 1 → one `frame_err` after the third bit; delivered frame is x1=0, y1=0, x2=1, y2=1.
- Reset mid-frame: two bits accepted, assert `reset` 1 cycle → all outputs at reset values; no `op_valid` and no `b_valid` until a new full frame arrives.
- Back-to-back: 16 frames covering all 4-bit patterns, `din_valid` and `op_ready` always high → 16 `b_valid` pulses, each `b_q` matching a reference model, frames spaced 5 cycles apart.
